// File: rtl/io_channel_wait_generator_pkg.sv
// Shared types for the XT-bus wait-state generator.
//   wait_state_t  : responder FSM states
//   cycle_kind_t  : bus command class of the accepted cycle
package io_channel_wait_generator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_COUNT,
        WAIT_DEVICE,
        RELEASE
    } wait_state_t;

    typedef enum logic [1:0] {
        CYCLE_IO_READ,
        CYCLE_IO_WRITE,
        CYCLE_MEM_READ,
        CYCLE_MEM_WRITE
    } cycle_kind_t;

    function automatic logic kind_is_io(input cycle_kind_t kind);
        return (kind == CYCLE_IO_READ) || (kind == CYCLE_IO_WRITE);
    endfunction

    function automatic logic kind_is_write(input cycle_kind_t kind);
        return (kind == CYCLE_IO_WRITE) || (kind == CYCLE_MEM_WRITE);
    endfunction

endpackage

// File: rtl/io_channel_wait_generator_bus_cycle_detect.sv
// Bus cycle detector: qualifies the raw XT commands with the address decodes
// and AEN, and produces the start-of-cycle edge plus the cycle classification.
// Ports:
//   clock, reset           : system clock, async active-high reset
//   *_n command/select/aen : raw bus signals (active-low)
//   active                 : a selected cycle is currently in progress
//   start                  : first clock of a selected cycle (active rising edge)
//   kind                   : class of the current cycle (priority-encoded)
module bus_cycle_detect
    import io_channel_wait_generator_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        io_read_n,
    input  logic        io_write_n,
    input  logic        memory_read_n,
    input  logic        memory_write_n,
    input  logic        address_enable_n,
    input  logic        io_select_n,
    input  logic        memory_select_n,
    output logic        active,
    output logic        start,
    output cycle_kind_t kind
);

    logic io_ok;
    logic mem_ok;
    logic io_rd;
    logic io_wr;
    logic mem_rd;
    logic mem_wr;
    logic prev_active;

    // I/O cycles only count while the CPU owns the bus (AEN inactive).
    assign io_ok  = ~io_select_n & address_enable_n;
    assign mem_ok = ~memory_select_n;
    assign io_rd  = io_ok  & ~io_read_n;
    assign io_wr  = io_ok  & ~io_write_n;
    assign mem_rd = mem_ok & ~memory_read_n;
    assign mem_wr = mem_ok & ~memory_write_n;

    assign active = io_rd | io_wr | mem_rd | mem_wr;
    assign start  = active & ~prev_active;

    always_comb begin
        kind = CYCLE_MEM_WRITE;
        if (io_rd)       kind = CYCLE_IO_READ;
        else if (io_wr)  kind = CYCLE_IO_WRITE;
        else if (mem_rd) kind = CYCLE_MEM_READ;
    end

    // Resets to 1 so a cycle already running when reset releases is ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) prev_active <= 1'b1;
        else       prev_active <= active;
    end

endmodule

// File: rtl/io_channel_wait_generator.sv
// Slave-side io_channel_ready source for slow on-board peripherals.
// Pulls ready low for a fixed number of clocks at the start of a selected
// bus cycle, optionally extended until device_done or a timeout.
// Ports:
//   clock, reset      : system clock, async active-high reset
//   io/memory cmds    : XT bus read/write strobes (active-low)
//   address_enable_n  : AEN inverted, 0 = DMA owns the bus
//   io/memory_select_n: external address decode for this device
//   device_done       : device has completed the access (level)
//   io_channel_ready  : 0 = insert wait states
//   device_strobe     : one-clock pulse when a cycle is accepted
//   cycle_is_io/write : class of the accepted cycle
//   cycle_timeout     : one-clock pulse when the device wait timed out
module io_channel_wait_generator
    import io_channel_wait_generator_pkg::*;
#(
    parameter int unsigned IO_WAIT     = 4,
    parameter int unsigned MEM_WAIT    = 1,
    parameter bit          USE_DONE    = 1'b1,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic io_read_n,
    input  logic io_write_n,
    input  logic memory_read_n,
    input  logic memory_write_n,
    input  logic address_enable_n,
    input  logic io_select_n,
    input  logic memory_select_n,
    input  logic device_done,
    output logic io_channel_ready,
    output logic device_strobe,
    output logic cycle_is_io,
    output logic cycle_is_write,
    output logic cycle_timeout
);

    localparam logic [COUNT_WIDTH-1:0] IO_LOAD  =
        (IO_WAIT  != 0) ? COUNT_WIDTH'(IO_WAIT  - 1) : '0;
    localparam logic [COUNT_WIDTH-1:0] MEM_LOAD =
        (MEM_WAIT != 0) ? COUNT_WIDTH'(MEM_WAIT - 1) : '0;
    localparam logic [COUNT_WIDTH-1:0] TIMER_LAST = COUNT_WIDTH'(TIMEOUT - 1);

    logic        active;
    logic        start;
    cycle_kind_t kind;

    wait_state_t            state, state_nxt;
    logic [COUNT_WIDTH-1:0] count, count_nxt;
    logic [COUNT_WIDTH-1:0] timer, timer_nxt;
    logic                   done_seen, done_seen_nxt;
    logic                   ready_nxt, strobe_nxt, is_io_nxt, is_write_nxt, timeout_nxt;
    logic                   start_is_io;
    logic                   wait_is_zero;
    logic [COUNT_WIDTH-1:0] wait_load;

    bus_cycle_detect u_detect (
        .clock            (clock),
        .reset            (reset),
        .io_read_n        (io_read_n),
        .io_write_n       (io_write_n),
        .memory_read_n    (memory_read_n),
        .memory_write_n   (memory_write_n),
        .address_enable_n (address_enable_n),
        .io_select_n      (io_select_n),
        .memory_select_n  (memory_select_n),
        .active           (active),
        .start            (start),
        .kind             (kind)
    );

    assign start_is_io  = kind_is_io(kind);
    assign wait_is_zero = start_is_io ? (IO_WAIT == 0) : (MEM_WAIT == 0);
    assign wait_load    = start_is_io ? IO_LOAD : MEM_LOAD;

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        timer_nxt     = timer;
        done_seen_nxt = done_seen | ((state != IDLE) & device_done);
        ready_nxt     = io_channel_ready;
        strobe_nxt    = 1'b0;
        is_io_nxt     = cycle_is_io;
        is_write_nxt  = cycle_is_write;
        timeout_nxt   = 1'b0;

        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (start) begin
                    strobe_nxt    = 1'b1;
                    is_io_nxt     = start_is_io;
                    is_write_nxt  = kind_is_write(kind);
                    done_seen_nxt = 1'b0;
                    timer_nxt     = '0;
                    if (!wait_is_zero) begin
                        state_nxt = WAIT_COUNT;
                        count_nxt = wait_load;
                        ready_nxt = 1'b0;
                    end else if (USE_DONE) begin
                        state_nxt = WAIT_DEVICE;
                        ready_nxt = 1'b0;
                    end else begin
                        state_nxt = RELEASE;
                    end
                end
            end
            WAIT_COUNT: begin
                if (!active) begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b1;
                end else if (count == '0) begin
                    if (USE_DONE) begin
                        state_nxt = WAIT_DEVICE;
                        timer_nxt = '0;
                    end else begin
                        state_nxt = RELEASE;
                        ready_nxt = 1'b1;
                    end
                end else begin
                    count_nxt = count - COUNT_WIDTH'(1);
                end
            end
            WAIT_DEVICE: begin
                // Abort beats done, and done beats timeout, in the same clock.
                if (!active) begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b1;
                end else if (done_seen || device_done) begin
                    state_nxt = RELEASE;
                    ready_nxt = 1'b1;
                end else if (timer == TIMER_LAST) begin
                    state_nxt   = RELEASE;
                    ready_nxt   = 1'b1;
                    timeout_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + COUNT_WIDTH'(1);
                end
            end
            RELEASE: begin
                ready_nxt = 1'b1;
                if (!active) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            count            <= '0;
            timer            <= '0;
            done_seen        <= 1'b0;
            io_channel_ready <= 1'b1;
            device_strobe    <= 1'b0;
            cycle_is_io      <= 1'b0;
            cycle_is_write   <= 1'b0;
            cycle_timeout    <= 1'b0;
        end else begin
            state            <= state_nxt;
            count            <= count_nxt;
            timer            <= timer_nxt;
            done_seen        <= done_seen_nxt;
            io_channel_ready <= ready_nxt;
            device_strobe    <= strobe_nxt;
            cycle_is_io      <= is_io_nxt;
            cycle_is_write   <= is_write_nxt;
            cycle_timeout    <= timeout_nxt;
        end
    end

endmodule
